// File: rtl/neuron_driver_if.sv
// Bundle of the neuron_driver control/data signals; master is the driver side,
// slave is the requester plus the downstream neuron.
interface neuron_driver_if #(
   parameter int N = 2
);
   logic            start;
   logic [32*N-1:0] x_in;
   logic            n_rst;
   logic [31:0]     x_out;
   logic            x_valid;
   logic            n_done;
   logic [31:0]     n_out;
   logic            busy;
   logic [31:0]     result;
   logic            result_valid;
   logic            timeout;

   modport master (
      input  start, x_in, n_done, n_out,
      output n_rst, x_out, x_valid, busy, result, result_valid, timeout
   );

   modport slave (
      output start, x_in, n_done, n_out,
      input  n_rst, x_out, x_valid, busy, result, result_valid, timeout
   );
endinterface

// File: rtl/neuron_driver.sv
// Sequences one neuron inference: clear pulse, N serial words, then wait for n_done or timeout.
// All outputs registered; start is only taken in IDLE, so no backpressure is exerted beyond busy.
module neuron_driver #(
   parameter int N        = 2,
   parameter int WAIT_MAX = 16
) (
   input  logic            clk,
   input  logic            rst,
   neuron_driver_if.master bus
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {IDLE, CLEAR, SEND, WAIT} state_t;

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_buf [N];
   logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_inc;
   logic [CNT_W-1:0] r_wait, w_wait_nxt, w_wait_inc;
   logic [31:0]      r_x_out, w_x_out_nxt;
   logic             r_x_valid, w_x_valid_nxt;
   logic             r_n_rst, w_n_rst_nxt;
   logic             r_busy;
   logic [31:0]      r_result, w_result_nxt;
   logic             r_result_valid, w_result_valid_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic             w_load;

   always_comb begin
      w_state_nxt        = r_state;
      w_idx_nxt          = r_idx;
      w_wait_nxt         = r_wait;
      w_idx_inc          = r_idx + IDX_W'(1);
      w_wait_inc         = r_wait + CNT_W'(1);
      w_x_out_nxt        = '0;
      w_x_valid_nxt      = 1'b0;
      w_n_rst_nxt        = 1'b0;
      w_result_nxt       = r_result;
      w_result_valid_nxt = 1'b0;
      w_timeout_nxt      = 1'b0;
      w_load             = 1'b0;
      // Outputs are computed for the state being entered so they line up with it.
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = CLEAR;
               w_load      = 1'b1;
               w_n_rst_nxt = 1'b1;
            end
         end
         CLEAR: begin
            w_state_nxt   = SEND;
            w_idx_nxt     = '0;
            w_wait_nxt    = '0;
            w_x_out_nxt   = r_buf[0];
            w_x_valid_nxt = 1'b1;
         end
         SEND: begin
            if (r_idx == IDX_W'(N - 1)) begin
               w_state_nxt = WAIT;
               w_wait_nxt  = '0;
            end else begin
               w_idx_nxt     = w_idx_inc;
               w_x_out_nxt   = r_buf[w_idx_inc];
               w_x_valid_nxt = 1'b1;
            end
         end
         WAIT: begin
            // n_done wins over the timeout on the final allowed cycle.
            if (bus.n_done) begin
               w_state_nxt        = IDLE;
               w_wait_nxt         = '0;
               w_result_nxt       = bus.n_out;
               w_result_valid_nxt = 1'b1;
            end else if (w_wait_inc == CNT_W'(WAIT_MAX)) begin
               w_state_nxt        = IDLE;
               w_wait_nxt         = '0;
               w_result_nxt       = '0;
               w_result_valid_nxt = 1'b1;
               w_timeout_nxt      = 1'b1;
            end else begin
               w_wait_nxt = w_wait_inc;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_idx          <= '0;
         r_wait         <= '0;
         r_x_out        <= '0;
         r_x_valid      <= 1'b0;
         r_n_rst        <= 1'b1;
         r_busy         <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_timeout      <= 1'b0;
         for (int k = 0; k < N; k++) r_buf[k] <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_idx          <= w_idx_nxt;
         r_wait         <= w_wait_nxt;
         r_x_out        <= w_x_out_nxt;
         r_x_valid      <= w_x_valid_nxt;
         r_n_rst        <= w_n_rst_nxt;
         r_busy         <= (w_state_nxt != IDLE);
         r_result       <= w_result_nxt;
         r_result_valid <= w_result_valid_nxt;
         r_timeout      <= w_timeout_nxt;
         if (w_load) begin
            for (int k = 0; k < N; k++) r_buf[k] <= bus.x_in[32*k +: 32];
         end
      end
   end

   assign bus.n_rst        = r_n_rst;
   assign bus.x_out        = r_x_out;
   assign bus.x_valid      = r_x_valid;
   assign bus.busy         = r_busy;
   assign bus.result       = r_result;
   assign bus.result_valid = r_result_valid;
   assign bus.timeout      = r_timeout;
endmodule
